// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES types, forward S-box table and FSM encoding for the iterative SubBytes stage.
package sub_bytes_iter_pkg;

  typedef logic [7:0] aes_byte_t;
  // Indexed [column][row]; column 0 / row 0 sits in the most significant byte.
  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, one byte out, purely combinational.
// No latency, no flow control.
module aes_sbox
  import sub_bytes_iter_pkg::*;
(
  input  aes_byte_t x,
  output aes_byte_t y
);

  assign y = SBOX[x];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: COLS_PER_CYCLE columns per clock, result valid ITER cycles after the BUSY entry edge.
// Backpressure: o and out_valid hold in DONE until out_ready; in_ready follows out_ready there.
module sub_bytes_iter
  import sub_bytes_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t state,
  output aes_state_t o,
  output logic       out_valid,
  input  logic       out_ready
);

  // STEP truncates to 0 for four columns per clock, so col_idx simply stays at 0.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  fsm_e       fsm_q, fsm_d;
  logic [1:0] col_idx;
  aes_state_t work;
  logic       in_xfer;

  aes_byte_t sb_out [COLS_PER_CYCLE][4];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (
        .x (work[col_idx + 2'(g)][r]),
        .y (sb_out[g][r])
      );
    end
  end

  assign in_xfer = in_valid && in_ready;

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = BUSY;
      end
      BUSY: begin
        if (col_idx == LAST_COL) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_d = in_valid ? BUSY : IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      col_idx <= 2'd0;
      work    <= '0;
      o       <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (in_xfer) begin
        work    <= state;
        col_idx <= 2'd0;
      end else if (fsm_q == BUSY) begin
        col_idx <= col_idx + STEP;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          for (int r = 0; r < 4; r++) begin
            o[col_idx + 2'(g)][r] <= sb_out[g][r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench: three instances (1, 2 and 4 columns per clock) checked against hand-computed S-box results.
module tb_sub_bytes_iter;
  import sub_bytes_iter_pkg::*;

  localparam int ITER [3] = '{4, 2, 1};

  localparam aes_state_t V_COL0  = 128'h193de3be000000000000000000000000;
  localparam aes_state_t E_COL0  = 128'hd42711ae636363636363636363636363;
  localparam aes_state_t V_53    = {16{8'h53}};
  localparam aes_state_t E_ED    = {16{8'hed}};
  localparam aes_state_t V_00    = {16{8'h00}};
  localparam aes_state_t E_63    = {16{8'h63}};
  localparam aes_state_t V_FF    = {16{8'hff}};
  localparam aes_state_t E_16    = {16{8'h16}};
  localparam aes_state_t V_FIPS  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_state_t E_FIPS  = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] iv = '0;
  logic [2:0] ordy = '0;
  logic [2:0] ir, ov;
  aes_state_t [2:0] ist = '0;
  aes_state_t [2:0] oo;

  int total = 0;
  int bad   = 0;

  sub_bytes_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .state(ist[0]),
    .o(oo[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  sub_bytes_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .state(ist[1]),
    .o(oo[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  sub_bytes_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .state(ist[2]),
    .o(oo[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  initial forever #5 clk = ~clk;

  // Presents s to instance k in IDLE; returns 1ns after the transfer edge.
  task automatic send(input int k, input aes_state_t s);
    @(posedge clk); #1;
    ist[k] = s;
    iv[k]  = 1'b1;
    @(posedge clk); #1;
    iv[k]  = 1'b0;
  endtask

  // Edges seen after the transfer edge until out_valid samples high (20 means timeout).
  task automatic wait_ov(input int k, output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ov[k]) break;
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (oo[0] !== '0 || ov !== 3'b000) begin
      bad++; $display("FAIL reset_hold: o=%h out_valid=%b want o=0 out_valid=000", oo[0], ov);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (ir !== 3'b111) begin
      bad++; $display("FAIL reset_in_ready: got %b want 111", ir);
    end
    total++;
    if (ov !== 3'b000 || oo[1] !== '0 || oo[2] !== '0) begin
      bad++; $display("FAIL reset_outputs: out_valid=%b want 000", ov);
    end
  endtask

  // Transfer edge counts as cycle 1, so first out_valid is expected on cycle ITER+1.
  task automatic test_single(input int k);
    int n;
    ordy[k] = 1'b1;
    send(k, V_COL0);
    wait_ov(k, n);
    total++;
    if (n + 1 !== ITER[k] + 1) begin
      bad++; $display("FAIL single_latency[%0d]: got %0d want %0d", k, n + 1, ITER[k] + 1);
    end
    total++;
    if (oo[k] !== E_COL0) begin
      bad++; $display("FAIL single_data[%0d]: got %h want %h", k, oo[k], E_COL0);
    end
    @(negedge clk);
    total++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
      bad++; $display("FAIL single_pulse[%0d]: out_valid=%b in_ready=%b want 0 1", k, ov[k], ir[k]);
    end
  endtask

  task automatic test_backpressure;
    int n;
    ordy[0] = 1'b0;
    send(0, V_53);
    wait_ov(0, n);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (oo[0] !== E_ED || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: o=%h ov=%b ir=%b want %h 1 0", i, oo[0], ov[0], ir[0], E_ED);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    @(negedge clk);
    total++;
    if (ov[0] !== 1'b1 || ir[0] !== 1'b1) begin
      bad++; $display("FAIL bp_release: ov=%b ir=%b want 1 1", ov[0], ir[0]);
    end
    @(negedge clk);
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || oo[0] !== E_ED) begin
      bad++; $display("FAIL bp_idle: ov=%b ir=%b o=%h want 0 1 %h", ov[0], ir[0], oo[0], E_ED);
    end
  endtask

  task automatic test_back_to_back;
    aes_state_t vin [3] = '{V_00, V_FF, V_FIPS};
    aes_state_t vexp [3] = '{E_63, E_16, E_FIPS};
    int sent = 0, got = 0, cyc = 0, last = 0;
    logic xin, xout;
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    ist[0]  = vin[0];
    iv[0]   = 1'b1;
    while (got < 3 && cyc < 60) begin
      @(negedge clk);
      xin  = iv[0] && ir[0];
      xout = ov[0] && ordy[0];
      if (xout) begin
        total++;
        if (oo[0] !== vexp[got]) begin
          bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, oo[0], vexp[got]);
        end
        if (got > 0) begin
          total++;
          if (cyc - last !== 5) begin
            bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", got, cyc - last);
          end
        end
        if (got < 2) begin
          total++;
          if (!xin) begin
            bad++; $display("FAIL b2b_accept_in_done[%0d]: in_ready=%b want 1", got, ir[0]);
          end
        end
        last = cyc;
        got++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (xin) begin
        sent++;
        if (sent < 3) ist[0] = vin[sent];
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    total++;
    if (got !== 3) begin
      bad++; $display("FAIL b2b_count: got %0d results want 3", got);
    end
  endtask

  task automatic test_stall_reject;
    int n = 0;
    ordy[0] = 1'b1;
    send(0, V_00);
    ist[0] = V_FF;
    iv[0]  = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      if (ov[0]) break;
      total++;
      if (ir[0] !== 1'b0) begin
        bad++; $display("FAIL stall_busy_ready[%0d]: got %b want 0", n, ir[0]);
      end
      @(posedge clk);
      n++;
    end
    total++;
    if (oo[0] !== E_63 || ir[0] !== 1'b1) begin
      bad++; $display("FAIL stall_first: o=%h ir=%b want %h 1", oo[0], ir[0], E_63);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_ov(0, n);
    total++;
    if (n !== 4 || oo[0] !== E_16) begin
      bad++; $display("FAIL stall_second: o=%h edges=%0d want %h 4", oo[0], n, E_16);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    ordy[0] = 1'b1;
    send(0, V_53);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (oo[0] !== '0 || ov[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear: o=%h ov=%b want 0 0", oo[0], ov[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_release: ir=%b ov=%b want 1 0", ir[0], ov[0]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || oo[0] !== '0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rstmid_stale: got %0d bad cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single(0);
    test_backpressure();
    test_back_to_back();
    test_stall_reject();
    test_reset_mid();
    test_single(1);
    test_single(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
